// File: rtl/mp64_phy_responder_pkg.sv
// ---------------------------------------------------------------------------
// mp64_phy_responder_pkg
// Shared definitions for the Megapad-64 PHY responder:
//   - phyr_state_e   : responder FSM state encoding
//   - PHY_WORD_BYTES : bytes per 64-bit memory word
//   - PHYR_LFSR_SEED : seed of the optional stall LFSR
//   - phyr_lfsr_next : one step of the 16-bit Fibonacci LFSR (taps 16,14,13,11)
// ---------------------------------------------------------------------------
package mp64_phy_responder_pkg;

    typedef enum logic [1:0] {
        PHYR_IDLE    = 2'd0,
        PHYR_WRITE   = 2'd1,
        PHYR_RD_WAIT = 2'd2,
        PHYR_READ    = 2'd3
    } phyr_state_e;

    localparam int          PHY_WORD_BYTES = 8;
    localparam logic [15:0] PHYR_LFSR_SEED = 16'hACE1;

    // Shift left, feedback from bits 16,14,13,11 (1-based) into bit 0.
    function automatic logic [15:0] phyr_lfsr_next(input logic [15:0] i_s);
        return {i_s[14:0], i_s[15] ^ i_s[13] ^ i_s[12] ^ i_s[10]};
    endfunction

endpackage

// File: rtl/mp64_phy_resp_ram.sv
// ---------------------------------------------------------------------------
// mp64_phy_resp_ram
// Single-port synchronous RAM, MEM_WORDS x 64 bits. One-cycle read latency,
// a cycle is either a write or a read. Storage has no reset.
// Ports:
//   clk      : clock
//   i_we     : write enable (1 = write i_wdata, 0 = read)
//   i_addr   : word index
//   i_wdata  : write data
//   o_rdata  : read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module mp64_phy_resp_ram
    import mp64_phy_responder_pkg::*;
#(
    parameter int MEM_WORDS = 8192,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [63:0]   i_wdata,
    output logic [63:0]   o_rdata
);

    logic [63:0] r_mem [MEM_WORDS];
    logic [63:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end else begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mp64_phy_responder.sv
// ---------------------------------------------------------------------------
// mp64_phy_responder
// Memory side of the Megapad-64 phy_* bus. Serves single and burst reads and
// writes from an on-chip word-addressed RAM with a fixed read latency RD_LAT.
// Optional feature macro: MP64_PHY_RESP_STALL_EN inserts pseudo-random
// phy_ready stalls (LFSR driven) in IDLE/WRITE.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   phy_req        : request / write-beat valid
//   phy_addr       : byte address of beat 0 (bits [2:0] ignored)
//   phy_wen        : 1 = write, 0 = read
//   phy_wdata      : write data for the current beat
//   phy_burst_len  : beats minus one
//   phy_rdata      : read data (0 when phy_rvalid is low)
//   phy_rvalid     : read beat valid
//   phy_ready      : request / beat accept
//   oor_err        : one-cycle pulse after accepting an out-of-range address
// ---------------------------------------------------------------------------
module mp64_phy_responder
    import mp64_phy_responder_pkg::*;
#(
    parameter int MEM_WORDS = 8192,
    parameter int RD_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        phy_req,
    input  logic [63:0] phy_addr,
    input  logic        phy_wen,
    input  logic [63:0] phy_wdata,
    input  logic [7:0]  phy_burst_len,
    output logic [63:0] phy_rdata,
    output logic        phy_rvalid,
    output logic        phy_ready,
    output logic        oor_err
);

    localparam int          AW         = $clog2(MEM_WORDS);
    localparam logic [AW-1:0] IDX_ONE  = AW'(1);
    localparam logic [63:0] ADDR_LIMIT = 64'(MEM_WORDS) * 64'(PHY_WORD_BYTES);

    phyr_state_e     r_state, w_state_nxt;
    logic            r_rst_done;
    logic [AW-1:0]   r_idx;
    logic [7:0]      r_cnt;
    logic [RD_LAT-1:0] r_vld, r_last;
    logic            r_oor;

    logic [AW-1:0]   w_base, w_ram_addr;
    logic            w_ram_we, w_issue, w_issue_last, w_accept, w_stall;
    logic [63:0]     w_ram_q, w_out_data;

    assign w_base   = phy_addr[3 +: AW];
    assign w_accept = phy_req && phy_ready;

`ifdef MP64_PHY_RESP_STALL_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (!rst_n) r_lfsr <= PHYR_LFSR_SEED;
        else        r_lfsr <= phyr_lfsr_next(r_lfsr);
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= PHYR_IDLE;
            r_rst_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rst_done <= 1'b1;
        end
    end

    // Next-state logic. READ issues RAM reads; RD_WAIT drains the delay line
    // until the beat marked last reaches the output.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PHYR_IDLE: begin
                if (w_accept) begin
                    if (phy_wen) w_state_nxt = (phy_burst_len == 8'd0) ? PHYR_IDLE : PHYR_WRITE;
                    else         w_state_nxt = (phy_burst_len == 8'd0) ? PHYR_RD_WAIT : PHYR_READ;
                end
            end
            PHYR_WRITE: begin
                if (w_accept && r_cnt == 8'd1) w_state_nxt = PHYR_IDLE;
            end
            PHYR_READ: begin
                if (r_cnt == 8'd1) w_state_nxt = PHYR_RD_WAIT;
            end
            PHYR_RD_WAIT: begin
                if (r_vld[RD_LAT-1] && r_last[RD_LAT-1]) w_state_nxt = PHYR_IDLE;
            end
            default: w_state_nxt = PHYR_IDLE;
        endcase
    end

    // Output / datapath control. Beat 0 of a read is issued in the accept
    // cycle straight from phy_addr so RD_LAT=1 is reachable.
    always_comb begin
        phy_ready    = 1'b0;
        w_ram_we     = 1'b0;
        w_ram_addr   = r_idx;
        w_issue      = 1'b0;
        w_issue_last = 1'b0;
        case (r_state)
            PHYR_IDLE: begin
                phy_ready  = r_rst_done && !w_stall;
                w_ram_addr = w_base;
                if (phy_ready && phy_req) begin
                    if (phy_wen) begin
                        w_ram_we = 1'b1;
                    end else begin
                        w_issue      = 1'b1;
                        w_issue_last = (phy_burst_len == 8'd0);
                    end
                end
            end
            PHYR_WRITE: begin
                phy_ready = r_rst_done && !w_stall;
                w_ram_we  = phy_ready && phy_req;
            end
            PHYR_READ: begin
                w_issue      = 1'b1;
                w_issue_last = (r_cnt == 8'd1);
            end
            default: ;
        endcase
    end

    // Beat counter and wrapping word index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx <= '0;
            r_cnt <= '0;
        end else if (r_state == PHYR_IDLE && w_accept) begin
            r_idx <= w_base + IDX_ONE;
            r_cnt <= phy_burst_len;
        end else if ((r_state == PHYR_WRITE && w_accept) || r_state == PHYR_READ) begin
            r_idx <= r_idx + IDX_ONE;
            r_cnt <= r_cnt - 8'd1;
        end
    end

    // Out-of-range flag is checked once, on the burst's first accept
    always_ff @(posedge clk) begin
        if (!rst_n) r_oor <= 1'b0;
        else        r_oor <= (r_state == PHYR_IDLE) && w_accept && (phy_addr >= ADDR_LIMIT);
    end

    // Valid / last delay line; stage 0 lines up with the RAM output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_last <= '0;
        end else begin
            r_vld[0]  <= w_issue;
            r_last[0] <= w_issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_last[i] <= r_last[i-1];
            end
        end
    end

    mp64_phy_resp_ram #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (phy_wdata),
        .o_rdata (w_ram_q)
    );

    // Data delay line (no reset; qualified by r_vld)
    if (RD_LAT == 1) begin : g_dly_none
        assign w_out_data = w_ram_q;
    end else begin : g_dly
        logic [63:0] r_dpipe [RD_LAT-1];
        always_ff @(posedge clk) begin
            r_dpipe[0] <= w_ram_q;
            for (int i = 1; i < RD_LAT-1; i++) begin
                r_dpipe[i] <= r_dpipe[i-1];
            end
        end
        assign w_out_data = r_dpipe[RD_LAT-2];
    end

    assign phy_rvalid = r_vld[RD_LAT-1];
    assign phy_rdata  = phy_rvalid ? w_out_data : 64'd0;
    assign oor_err    = r_oor;

endmodule
